// File: rtl/move_sequencer_if.sv
// Signal bundle between the playfield control logic and the move sequencer:
// run/button/enable requests in, move/lock pulses and busy out.
interface move_sequencer_if;
  logic run;
  logic btn_up, btn_down, btn_left, btn_right;
  logic up_en, down_en, left_en, right_en;
  logic move_up, move_down, move_left, move_right;
  logic lock_o;
  logic busy;

  modport master (
    output run, btn_up, btn_down, btn_left, btn_right,
    output up_en, down_en, left_en, right_en,
    input  move_up, move_down, move_left, move_right, lock_o, busy
  );

  modport slave (
    input  run, btn_up, btn_down, btn_left, btn_right,
    input  up_en, down_en, left_en, right_en,
    output move_up, move_down, move_left, move_right, lock_o, busy
  );
endinterface

// File: rtl/move_sequencer.sv
// Arbitrates button edges and gravity ticks into one-cycle move pulses,
// with a settle hold-off after each move and a lock after repeated blocked gravity.
//   state    | meaning
//   S_IDLE   | waiting for a pending request
//   S_ISSUE  | evaluating the selected request against its enable
//   S_SETTLE | holding off while the enable flags recompute
module move_sequencer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int LOCK_TICKS = 2,
  parameter int SETTLE     = 2
) (
  input  logic            clk,
  input  logic            reset,
  move_sequencer_if.slave bus
);
  localparam int              GW          = $clog2(TICK_DIV);
  localparam logic [GW-1:0]   GRAV_LAST   = GW'(TICK_DIV - 1);
  localparam logic [3:0]      LOCK_LIM    = 4'(LOCK_TICKS);
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_t;
  // Encodings double as bit positions in pend_q
  typedef enum logic [2:0] {SEL_GRAV, SEL_DOWN, SEL_LEFT, SEL_RIGHT, SEL_UP} sel_t;

  state_t        state_q, state_d;
  sel_t          sel_q, sel_d;
  logic [GW-1:0] grav_cnt_q, grav_cnt_d;
  logic [4:0]    pend_q, pend_d;      // {up, right, left, down, grav}
  logic [3:0]    btn_q, btn_d;        // {up, right, left, down}
  logic [3:0]    settle_q, settle_d;
  logic [3:0]    blk_q, blk_d;
  logic [3:0]    mv_q, mv_d;          // {up, right, left, down}
  logic          lock_q, lock_d;
  logic          busy_q, busy_d;

  logic [3:0] btn_now, en_now, dir_oh;
  logic [4:0] set_v, clr_v;
  logic       grav_wrap, dir_en, is_down;

  assign btn_now = {bus.btn_up, bus.btn_right, bus.btn_left, bus.btn_down};
  assign en_now  = {bus.up_en, bus.right_en, bus.left_en, bus.down_en};

  always_comb begin
    btn_d      = btn_now;
    grav_wrap  = (grav_cnt_q == GRAV_LAST);
    grav_cnt_d = grav_wrap ? '0 : grav_cnt_q + GW'(1);
    set_v      = {btn_now & ~btn_q, grav_wrap};
    clr_v      = '0;
    state_d    = state_q;
    sel_d      = sel_q;
    settle_d   = settle_q;
    blk_d      = blk_q;
    mv_d       = '0;
    lock_d     = 1'b0;
    dir_oh     = '0;
    is_down    = 1'b0;

    case (sel_q)
      SEL_GRAV, SEL_DOWN: begin
        dir_oh  = 4'b0001;
        is_down = 1'b1;
      end
      SEL_LEFT:  dir_oh = 4'b0010;
      SEL_RIGHT: dir_oh = 4'b0100;
      SEL_UP:    dir_oh = 4'b1000;
      default:   dir_oh = '0;
    endcase
    dir_en = |(dir_oh & en_now);

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d = S_ISSUE;
          if (pend_q[0])      sel_d = SEL_GRAV;
          else if (pend_q[1]) sel_d = SEL_DOWN;
          else if (pend_q[2]) sel_d = SEL_LEFT;
          else if (pend_q[3]) sel_d = SEL_RIGHT;
          else                sel_d = SEL_UP;
        end
      end
      S_ISSUE: begin
        clr_v = 5'b00001 << sel_q;
        if (dir_en) begin
          mv_d     = dir_oh;
          if (is_down) blk_d = '0;
          state_d  = S_SETTLE;
          settle_d = SETTLE_LOAD;
        end else if (sel_q == SEL_GRAV) begin
          if (blk_q + 4'd1 == LOCK_LIM) begin
            lock_d   = 1'b1;
            blk_d    = '0;
            clr_v    = '1;
            state_d  = S_SETTLE;
            settle_d = SETTLE_LOAD;
          end else begin
            blk_d   = blk_q + 4'd1;
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_IDLE;
        else                settle_d = settle_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // A set on the same edge as a clear wins, so a fresh edge is never lost
    pend_d = (pend_q & ~clr_v) | set_v;

    if (!bus.run) begin
      state_d    = S_IDLE;
      pend_d     = '0;
      grav_cnt_d = '0;
      blk_d      = '0;
      settle_d   = '0;
      mv_d       = '0;
      lock_d     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= SEL_GRAV;
      grav_cnt_q <= '0;
      pend_q     <= '0;
      btn_q      <= '1;
      settle_q   <= '0;
      blk_q      <= '0;
      mv_q       <= '0;
      lock_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grav_cnt_q <= grav_cnt_d;
      pend_q     <= pend_d;
      btn_q      <= btn_d;
      settle_q   <= settle_d;
      blk_q      <= blk_d;
      mv_q       <= mv_d;
      lock_q     <= lock_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.move_down  = mv_q[0];
  assign bus.move_left  = mv_q[1];
  assign bus.move_right = mv_q[2];
  assign bus.move_up    = mv_q[3];
  assign bus.lock_o     = lock_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer (TICK_DIV=16, LOCK_TICKS=2, SETTLE=2);
// outputs sampled on the falling edge, k counts rising edges since the last restart.
module tb_move_sequencer;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  move_sequencer_if bus ();

  move_sequencer #(.TICK_DIV(16), .LOCK_TICKS(2), .SETTLE(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // {move_up, move_right, move_left, move_down, lock_o, busy}
  function automatic logic [5:0] ev(input bit up, input bit rt, input bit lf,
                                     input bit dn, input bit lk, input bit bz);
    return {up, rt, lf, dn, lk, bz};
  endfunction

  task automatic chk(input string tag, input int k, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {bus.move_up, bus.move_right, bus.move_left, bus.move_down, bus.lock_o, bus.busy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // One edge with run=0 flushes everything and restarts the gravity phase
  task automatic restart(input string tag);
    bus.run = 1'b0;
    @(negedge clk);
    chk(tag, 0, 6'b0);
    bus.run = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset         = 1'b1;
    bus.run       = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b0;
    bus.up_en     = 1'b1;
    bus.down_en   = 1'b1;
    bus.left_en   = 1'b1;
    bus.right_en  = 1'b1;

    @(negedge clk);
    chk("reset_values", 0, 6'b0);
    reset = 1'b0;

    // 1: left held through reset never moves; gravity every 16 edges
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      chk("t1_held_grav", k, ev(0, 0, 0, k == 18 || k == 34, 0,
                                (k >= 17 && k <= 19) || (k >= 33 && k <= 35)));
    end
    bus.btn_left = 1'b0;

    // 2: left press sampled at edge 3 -> pulse after edge 5, busy 3 cycles
    restart("t2_flush");
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t2_left", k, ev(0, 0, k == 5, 0, 0, k >= 4 && k <= 6));
      if (k == 2) bus.btn_left = 1'b1;
    end
    bus.btn_left = 1'b0;

    // 3: blocked left -> busy 1 cycle, no pulse, pend cleared; then allowed press
    bus.left_en = 1'b0;
    restart("t3_flush");
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      chk("t3_blocked", k, ev(0, 0, k == 11, 0, 0, k == 4 || (k >= 10 && k <= 12)));
      if (k == 2) bus.btn_left = 1'b1;
      if (k == 6) begin
        bus.btn_left = 1'b0;
        bus.left_en  = 1'b1;
      end
      if (k == 8) bus.btn_left = 1'b1;
    end
    bus.btn_left = 1'b0;

    // 4: gravity wrap and right edge together -> down first, right 4 cycles later
    restart("t4_flush");
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      chk("t4_prio", k, ev(0, k == 22, 0, k == 18, 0,
                           (k >= 17 && k <= 19) || (k >= 21 && k <= 23)));
      if (k == 15) bus.btn_right = 1'b1;
    end
    bus.btn_right = 1'b0;

    // 5: down blocked for two ticks -> lock after second wrap, pending down flushed
    bus.down_en = 1'b0;
    restart("t5_flush");
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("t5_lock", k, ev(0, 0, 0, 0, k == 34, k == 17 || (k >= 33 && k <= 35)));
      if (k == 32) bus.btn_down = 1'b1;
    end
    bus.btn_down = 1'b0;
    bus.down_en  = 1'b1;

    // 6: run drop mid-SETTLE, press while frozen, gravity restarts from run rise
    restart("t6_flush");
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("t6_run", k, ev(0, 0, k == 5, k == 28, 0,
                          k == 4 || k == 5 || (k >= 27 && k <= 29)));
      if (k == 2)  bus.btn_left  = 1'b1;
      if (k == 5)  bus.run       = 1'b0;
      if (k == 7)  bus.btn_right = 1'b1;
      if (k == 10) bus.run       = 1'b1;
    end
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;

    // 7: asynchronous reset during SETTLE clears outputs at once
    restart("t7_flush");
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t7_pre", k, ev(0, 0, k == 5, 0, 0, k >= 4));
      if (k == 2) bus.btn_left = 1'b1;
    end
    #2 reset = 1'b1;
    #1 chk("t7_async_rst", 0, 6'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t7_post", k, 6'b0);
    end
    bus.btn_left = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
